// File: rtl/output_readout_pkg.sv
// Shared types for the output BRAM readout scheduler: FSM states and the
// entry format carried from the BRAM capture stage to the output stream.
package output_readout_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_BRAM_NUM   = 4;
  localparam int DEFAULT_BRAM_DEPTH = 1152;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } readout_state_t;

  typedef struct packed {
    logic [DEFAULT_DATA_WIDTH-1:0]       data;
    logic [$clog2(DEFAULT_BRAM_NUM)-1:0] bank;
    logic                                last;
  } readout_entry_t;

endpackage

// File: rtl/readout_skid_fifo.sv
// Two-entry FIFO between the BRAM capture stage and the output stream.
// The caller guarantees no push when full and no pop when empty.
module readout_skid_fifo
  import output_readout_pkg::*;
#(
  parameter type entry_t = readout_entry_t
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  entry_t     entry,
  input  logic       pop,
  output logic [1:0] count,
  output entry_t     head
);

  entry_t mem [2];
  logic   wr_ptr;
  logic   rd_ptr;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  // NOTE: storage is not reset; entries are only visible once count says they were written.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= entry;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/output_bram_readout_scheduler.sv
// Reads every output BRAM bank address-major/bank-minor after a conv tile and
// serialises the returned words into one valid/ready stream.
module output_bram_readout_scheduler
  import output_readout_pkg::*;
#(
  parameter int DATA_WIDTH                = DEFAULT_DATA_WIDTH,
  parameter int OUTPUT_BRAM_NUM           = DEFAULT_BRAM_NUM,
  parameter int OUTPUT_BRAM_DEPTH         = DEFAULT_BRAM_DEPTH,
  parameter int OUTPUT_BRAM_ADDRESS_WIDTH = $clog2(OUTPUT_BRAM_DEPTH),
  parameter int BANK_WIDTH                = $clog2(OUTPUT_BRAM_NUM)
) (
  input  logic                                 i_clock,
  input  logic                                 i_reset,
  input  logic                                 i_start,
  input  logic [OUTPUT_BRAM_ADDRESS_WIDTH-1:0] i_base_address,
  input  logic [OUTPUT_BRAM_ADDRESS_WIDTH:0]   i_word_count,
  input  logic                                 i_reset_busy,
  output logic                                 o_renable  [0:OUTPUT_BRAM_NUM-1],
  output logic [OUTPUT_BRAM_ADDRESS_WIDTH-1:0] o_raddress [0:OUTPUT_BRAM_NUM-1],
  input  logic [DATA_WIDTH-1:0]                i_bram_data [0:OUTPUT_BRAM_NUM-1],
  output logic [DATA_WIDTH-1:0]                o_data,
  output logic [BANK_WIDTH-1:0]                o_bank,
  output logic                                 o_valid,
  input  logic                                 i_ready,
  output logic                                 o_last,
  output logic                                 o_busy,
  output logic                                 o_done
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [BANK_WIDTH-1:0] bank;
    logic                  last;
  } entry_t;

  localparam logic [BANK_WIDTH-1:0]                LAST_BANK = BANK_WIDTH'(OUTPUT_BRAM_NUM - 1);
  localparam logic [OUTPUT_BRAM_ADDRESS_WIDTH:0]   ONE_LEFT  = (OUTPUT_BRAM_ADDRESS_WIDTH + 1)'(1);

  readout_state_t                       state;
  readout_state_t                       state_next;
  logic [OUTPUT_BRAM_ADDRESS_WIDTH-1:0] address;
  logic [OUTPUT_BRAM_ADDRESS_WIDTH:0]   address_left;
  logic [BANK_WIDTH-1:0]                bank;
  logic                                 inflight;
  logic [BANK_WIDTH-1:0]                bank_d1;
  logic                                 last_d1;
  logic                                 issue;
  logic                                 final_read;
  logic                                 pop;
  logic [2:0]                           credit_used;
  logic [1:0]                           fifo_count;
  entry_t                               push_entry;
  entry_t                               head;

  assign pop        = o_valid & i_ready;
  assign final_read = (bank == LAST_BANK) && (address_left == ONE_LEFT);

  // A read is only launched when its word is guaranteed a FIFO slot on return.
  assign credit_used = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue       = (state == READ) && !i_reset_busy && (credit_used < 3'd2);

  always_ff @(posedge i_clock) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    unique case (state)
      IDLE:    if (i_start) state_next = (i_word_count != '0) ? READ : DONE;
      READ:    if (issue && final_read) state_next = DRAIN;
      DRAIN:   if (pop && head.last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      address      <= '0;
      address_left <= '0;
      bank         <= '0;
      inflight     <= 1'b0;
      bank_d1      <= '0;
      last_d1      <= 1'b0;
    end else begin
      inflight <= issue;
      bank_d1  <= bank;
      last_d1  <= final_read;
      if (state == IDLE && i_start) begin
        address      <= i_base_address;
        address_left <= i_word_count;
        bank         <= '0;
      end else if (issue) begin
        if (bank == LAST_BANK) begin
          bank         <= '0;
          address      <= address + 1'b1;
          address_left <= address_left - 1'b1;
        end else begin
          bank <= bank + 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int b = 0; b < OUTPUT_BRAM_NUM; b++) begin
      o_renable[b]  = issue && (bank == BANK_WIDTH'(b));
      o_raddress[b] = address;
    end
  end

  assign push_entry = '{data: i_bram_data[bank_d1], bank: bank_d1, last: last_d1};

  readout_skid_fifo #(
    .entry_t (entry_t)
  ) u_fifo (
    .clock (i_clock),
    .reset (i_reset),
    .push  (inflight),
    .entry (push_entry),
    .pop   (pop),
    .count (fifo_count),
    .head  (head)
  );

  assign o_valid = (fifo_count != 2'd0);
  assign o_data  = o_valid ? head.data : '0;
  assign o_bank  = o_valid ? head.bank : '0;
  assign o_last  = o_valid & head.last;
  assign o_busy  = (state != IDLE);
  assign o_done  = (state == DONE);

endmodule
